// File: rtl/nmr_cpmg_multiscan_seq_if.sv
// Control, timing configuration and pulse outputs of the CPMG multiscan sequencer.
// The sequencer uses the slave modport; the driver of the run settings uses master.
interface nmr_cpmg_multiscan_seq_if #(
    parameter int DBW        = 32,
    parameter int NUM_PHASES = 4,
    parameter int PHASE_W    = 2
);
    logic                          START;
    logic                          ABORT;
    logic [DBW-1:0]                T1_PULSE180;
    logic [DBW-1:0]                T1_DELAY;
    logic [DBW-1:0]                PULSE90;
    logic [DBW-1:0]                DELAY_NO_ACQ;
    logic [DBW-1:0]                PULSE180;
    logic [DBW-1:0]                DELAY_WITH_ACQ;
    logic [DBW-1:0]                ECHO_PER_SCAN;
    logic [DBW-1:0]                SAMPLES_PER_ECHO;
    logic [DBW-1:0]                ADC_INIT_DELAY;
    logic [DBW-1:0]                RX_DELAY;
    logic [DBW-1:0]                SCAN_COUNT;
    logic [NUM_PHASES*PHASE_W-1:0] PHASE_TABLE;
    logic                          FSMSTAT;
    logic                          DONE;
    logic                          RF_EN;
    logic [PHASE_W-1:0]            RF_PHASE;
    logic                          EN_RX;
    logic                          TX_SD;
    logic                          ACQ_WND;
    logic [DBW-1:0]                ECHO_IDX;
    logic [DBW-1:0]                SCAN_IDX;

    modport master (
        output START, ABORT, T1_PULSE180, T1_DELAY, PULSE90, DELAY_NO_ACQ,
        output PULSE180, DELAY_WITH_ACQ, ECHO_PER_SCAN, SAMPLES_PER_ECHO,
        output ADC_INIT_DELAY, RX_DELAY, SCAN_COUNT, PHASE_TABLE,
        input  FSMSTAT, DONE, RF_EN, RF_PHASE, EN_RX, TX_SD, ACQ_WND,
        input  ECHO_IDX, SCAN_IDX
    );

    modport slave (
        input  START, ABORT, T1_PULSE180, T1_DELAY, PULSE90, DELAY_NO_ACQ,
        input  PULSE180, DELAY_WITH_ACQ, ECHO_PER_SCAN, SAMPLES_PER_ECHO,
        input  ADC_INIT_DELAY, RX_DELAY, SCAN_COUNT, PHASE_TABLE,
        output FSMSTAT, DONE, RF_EN, RF_PHASE, EN_RX, TX_SD, ACQ_WND,
        output ECHO_IDX, SCAN_IDX
    );
endinterface

// File: rtl/nmr_cpmg_multiscan_seq.sv
// NMR pulse-program sequencer: optional T1 inversion, CPMG echo train, multiple scans
// with phase cycling. Outputs are registered from the next-state decode.
module nmr_cpmg_multiscan_seq #(
    parameter int DATABUS_WIDTH = 32,
    parameter int NUM_PHASES    = 4,
    parameter int PHASE_W       = 2
) (
    input logic                   PULSEPROG_CLK,
    input logic                   RESET,
    nmr_cpmg_multiscan_seq_if.slave bus
);
    localparam int DBW = DATABUS_WIDTH;
    localparam int TBW = NUM_PHASES * PHASE_W;
    localparam int PIW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_T1P, S_T1D, S_P90, S_DNA, S_P180, S_DACQ, S_SEND, S_DONE
    } state_t;

    typedef struct packed {
        logic [DBW-1:0] t1p, t1d, p90, dna, p180, dacq;
        logic [DBW-1:0] echoes, samples, adc, rx, scans;
        logic [TBW-1:0] tbl;
    } cfg_t;

    state_t             state_q, state_d;
    cfg_t               cfg_q, cfg_d;
    logic [DBW-1:0]     cnt_q, cnt_d, echo_q, echo_d, scan_q, scan_d;
    logic [PIW-1:0]     ph_q, ph_d;
    logic               fsmstat_q, fsmstat_d, done_q, done_d;
    logic               rf_en_q, rf_en_d, en_rx_q, en_rx_d;
    logic               tx_sd_q, tx_sd_d, acq_q, acq_d;
    logic [PHASE_W-1:0] rf_phase_q, rf_phase_d, ph_sel;
    logic [DBW-1:0]     len, scans_eff;
    logic [DBW:0]       acq_end;
    logic               last, go_t1, go_p90, go_dna, go_echo;

    always_comb begin
        len = DBW'(1);
        unique case (state_q)
            S_T1P:   len = cfg_q.t1p;
            S_T1D:   len = cfg_q.t1d;
            S_P90:   len = cfg_q.p90;
            S_DNA:   len = cfg_q.dna;
            S_P180:  len = cfg_q.p180;
            S_DACQ:  len = cfg_q.dacq;
            default: len = DBW'(1);
        endcase
        last      = (cnt_q == len - DBW'(1));
        scans_eff = (cfg_q.scans == '0) ? DBW'(1) : cfg_q.scans;
    end

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        cnt_d   = cnt_q + DBW'(1);
        echo_d  = echo_q;
        scan_d  = scan_q;
        ph_d    = ph_q;
        go_t1   = 1'b0;
        go_p90  = 1'b0;
        go_dna  = 1'b0;
        go_echo = 1'b0;
        unique case (state_q)
            S_IDLE: if (bus.START) begin
                cfg_d = '{bus.T1_PULSE180, bus.T1_DELAY, bus.PULSE90,
                          bus.DELAY_NO_ACQ, bus.PULSE180, bus.DELAY_WITH_ACQ,
                          bus.ECHO_PER_SCAN, bus.SAMPLES_PER_ECHO,
                          bus.ADC_INIT_DELAY, bus.RX_DELAY, bus.SCAN_COUNT,
                          bus.PHASE_TABLE};
                scan_d = '0;
                echo_d = '0;
                ph_d   = '0;
                go_t1  = 1'b1;
            end
            S_T1P: if (last) begin
                if (cfg_q.t1d != '0) begin
                    state_d = S_T1D;
                    cnt_d   = '0;
                end else go_p90 = 1'b1;
            end
            S_T1D: if (last) go_p90 = 1'b1;
            S_P90: if (last) go_dna = 1'b1;
            S_DNA: if (last) go_echo = 1'b1;
            S_P180: if (last) begin
                if (cfg_q.dacq != '0) begin
                    state_d = S_DACQ;
                    cnt_d   = '0;
                end else begin
                    echo_d  = echo_q + DBW'(1);
                    go_echo = 1'b1;
                end
            end
            S_DACQ: if (last) begin
                echo_d  = echo_q + DBW'(1);
                go_echo = 1'b1;
            end
            S_SEND: begin
                scan_d = scan_q + DBW'(1);
                ph_d   = (ph_q == PIW'(NUM_PHASES - 1)) ? '0 : ph_q + PIW'(1);
                if (scan_d >= scans_eff) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    echo_d = '0;
                    go_t1  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
        // Zero-length states collapse so the next non-empty state starts this cycle.
        if (go_t1) begin
            cnt_d = '0;
            if (cfg_d.t1p != '0) state_d = S_T1P;
            else go_p90 = 1'b1;
        end
        if (go_p90) begin
            cnt_d = '0;
            if (cfg_d.p90 != '0) state_d = S_P90;
            else go_dna = 1'b1;
        end
        if (go_dna) begin
            cnt_d = '0;
            if (cfg_d.dna != '0) state_d = S_DNA;
            else go_echo = 1'b1;
        end
        if (go_echo) begin
            cnt_d = '0;
            if (echo_d >= cfg_d.echoes) state_d = S_SEND;
            else if (cfg_d.p180 != '0) state_d = S_P180;
            else if (cfg_d.dacq != '0) state_d = S_DACQ;
            else begin
                echo_d  = cfg_d.echoes;
                state_d = S_SEND;
            end
        end
        if (bus.ABORT) begin
            state_d = S_IDLE;
            cfg_d   = cfg_q;
            cnt_d   = '0;
            echo_d  = echo_q;
            scan_d  = scan_q;
            ph_d    = ph_q;
        end
    end

    always_comb begin
        fsmstat_d  = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        rf_en_d    = (state_d == S_T1P) || (state_d == S_P90) || (state_d == S_P180);
        tx_sd_d    = (state_d == S_DACQ);
        en_rx_d    = tx_sd_d && (cnt_d >= cfg_d.rx);
        acq_end    = {1'b0, cfg_d.adc} + {1'b0, cfg_d.samples};
        acq_d      = tx_sd_d && (cnt_d >= cfg_d.adc) && ({1'b0, cnt_d} < acq_end);
        ph_sel     = cfg_d.tbl[int'(ph_d)*PHASE_W +: PHASE_W];
        rf_phase_d = rf_phase_q;
        if (state_d == S_P90) rf_phase_d = ph_sel;
        else if (state_d == S_T1P || state_d == S_P180) rf_phase_d = ph_sel + PHASE_W'(1);
    end

    always_ff @(posedge PULSEPROG_CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cfg_q      <= '0;
            cnt_q      <= '0;
            echo_q     <= '0;
            scan_q     <= '0;
            ph_q       <= '0;
            fsmstat_q  <= 1'b0;
            done_q     <= 1'b0;
            rf_en_q    <= 1'b0;
            en_rx_q    <= 1'b0;
            tx_sd_q    <= 1'b0;
            acq_q      <= 1'b0;
            rf_phase_q <= '0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            cnt_q      <= cnt_d;
            echo_q     <= echo_d;
            scan_q     <= scan_d;
            ph_q       <= ph_d;
            fsmstat_q  <= fsmstat_d;
            done_q     <= done_d;
            rf_en_q    <= rf_en_d;
            en_rx_q    <= en_rx_d;
            tx_sd_q    <= tx_sd_d;
            acq_q      <= acq_d;
            rf_phase_q <= rf_phase_d;
        end
    end

    assign bus.FSMSTAT  = fsmstat_q;
    assign bus.DONE     = done_q;
    assign bus.RF_EN    = rf_en_q;
    assign bus.RF_PHASE = rf_phase_q;
    assign bus.EN_RX    = en_rx_q;
    assign bus.TX_SD    = tx_sd_q;
    assign bus.ACQ_WND  = acq_q;
    assign bus.ECHO_IDX = echo_q;
    assign bus.SCAN_IDX = scan_q;
endmodule

// File: tb/tb_nmr_cpmg_multiscan_seq.sv
// Directed bench for the CPMG multiscan sequencer: per-run totals from a vector
// table, then cycle-level sequences for phases, T1, abort, reset and back-to-back runs.
module tb_nmr_cpmg_multiscan_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nmr_cpmg_multiscan_seq_if #(.DBW(32), .NUM_PHASES(4), .PHASE_W(2)) bus ();

    nmr_cpmg_multiscan_seq #(
        .DATABUS_WIDTH(32), .NUM_PHASES(4), .PHASE_W(2)
    ) dut (
        .PULSEPROG_CLK(clk),
        .RESET(rst),
        .bus(bus)
    );

    typedef struct {
        int unsigned t1p, t1d, p90, dna, p180, dacq, echo, samp, adc, rx, scans;
        int busy, rf, tx, rxon, acq, dn, scan_end, echo_end;
    } vec_t;

    int errors = 0;
    int checks = 0;
    vec_t vt[7];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int unsigned t1p, t1d, p90, dna, p180, dacq,
                                echo, samp, adc, rx, scans,
                                input int busy, rf, tx, rxon, acq, dn, se, ee);
        vec_t v;
        v.t1p = t1p; v.t1d = t1d; v.p90 = p90; v.dna = dna; v.p180 = p180;
        v.dacq = dacq; v.echo = echo; v.samp = samp; v.adc = adc; v.rx = rx;
        v.scans = scans; v.busy = busy; v.rf = rf; v.tx = tx; v.rxon = rxon;
        v.acq = acq; v.dn = dn; v.scan_end = se; v.echo_end = ee;
        return v;
    endfunction

    task automatic set_cfg(input vec_t v);
        bus.T1_PULSE180      = v.t1p;
        bus.T1_DELAY         = v.t1d;
        bus.PULSE90          = v.p90;
        bus.DELAY_NO_ACQ     = v.dna;
        bus.PULSE180         = v.p180;
        bus.DELAY_WITH_ACQ   = v.dacq;
        bus.ECHO_PER_SCAN    = v.echo;
        bus.SAMPLES_PER_ECHO = v.samp;
        bus.ADC_INIT_DELAY   = v.adc;
        bus.RX_DELAY         = v.rx;
        bus.SCAN_COUNT       = v.scans;
    endtask

    task automatic kick();
        @(negedge clk);
        bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!bus.FSMSTAT) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({nm, "_idle"}, ok, 1);
    endtask

    task automatic wait_dacq(input int echo, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.TX_SD && bus.ECHO_IDX == echo) begin
                ok = 1'b1;
                break;
            end
        end
        chk({nm, "_reach_dacq"}, ok, 1);
    endtask

    initial begin
        int busy, rf, tx, rxon, acq, dn;
        bit fin, prev;
        int np;
        int ph[10];
        int exp_ph[10];
        logic rfa[40];
        logic [1:0] pha[40];
        logic dna_[40];
        logic fs[40];
        logic dns[40];

        rst = 1'b1;
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        bus.PHASE_TABLE = 8'hE4;
        set_cfg(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_fsmstat", bus.FSMSTAT, 0);
        chk("rst_done", bus.DONE, 0);
        chk("rst_gates", {bus.RF_EN, bus.EN_RX, bus.TX_SD, bus.ACQ_WND}, 0);
        chk("rst_phase", bus.RF_PHASE, 0);
        chk("rst_idx", {bus.ECHO_IDX, bus.SCAN_IDX}, 0);

        //      t1p t1d p90 dna p180 dacq echo samp adc rx scans | busy rf tx rxon acq dn se ee
        vt[0] = mk(0, 0, 4, 4, 8, 32, 3, 10, 5, 2, 1,   130, 28, 96, 90, 30, 1, 1, 3);
        vt[1] = mk(0, 0, 4, 4, 8, 32, 3, 10, 28, 0, 1,  130, 28, 96, 96, 12, 1, 1, 3);
        vt[2] = mk(0, 0, 4, 4, 8, 32, 3, 32'h20, 32'hFFFF_FFF0, 40, 1,
                   130, 28, 96, 0, 0, 1, 1, 3);
        vt[3] = mk(6, 10, 4, 4, 8, 32, 0, 10, 5, 2, 1,  26, 10, 0, 0, 0, 1, 1, 0);
        vt[4] = mk(0, 0, 4, 4, 8, 32, 3, 10, 5, 2, 0,   130, 28, 96, 90, 30, 1, 1, 3);
        vt[5] = mk(2, 0, 3, 0, 5, 7, 2, 3, 0, 0, 2,     61, 30, 28, 28, 12, 1, 2, 2);
        vt[6] = mk(0, 0, 2, 1, 0, 5, 2, 5, 3, 4, 1,     15, 2, 10, 2, 4, 1, 1, 2);

        for (int v = 0; v < 7; v++) begin
            string n;
            n = $sformatf("v%0d", v);
            set_cfg(vt[v]);
            kick();
            bus.PULSE90 = 99;
            busy = 0; rf = 0; tx = 0; rxon = 0; acq = 0; dn = 0; fin = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                if (!bus.FSMSTAT) begin
                    fin = 1'b1;
                    break;
                end
                busy++;
                rf += int'(bus.RF_EN);
                tx += int'(bus.TX_SD);
                rxon += int'(bus.EN_RX);
                acq += int'(bus.ACQ_WND);
                dn += int'(bus.DONE);
                @(negedge clk);
            end
            chk({n, "_finished"}, fin, 1);
            chk({n, "_busy"}, busy, vt[v].busy);
            chk({n, "_rf_en"}, rf, vt[v].rf);
            chk({n, "_tx_sd"}, tx, vt[v].tx);
            chk({n, "_en_rx"}, rxon, vt[v].rxon);
            chk({n, "_acq_wnd"}, acq, vt[v].acq);
            chk({n, "_done"}, dn, vt[v].dn);
            chk({n, "_scan_idx"}, bus.SCAN_IDX, vt[v].scan_end);
            chk({n, "_echo_idx"}, bus.ECHO_IDX, vt[v].echo_end);
        end

        // Phase cycling across five scans: P90 then P180 of each scan.
        exp_ph = '{0, 1, 1, 2, 2, 3, 3, 0, 0, 1};
        set_cfg(mk(0, 0, 2, 1, 2, 2, 1, 1, 0, 0, 5, 0,0,0,0,0,0,0,0));
        kick();
        np = 0; prev = 1'b0;
        for (int c = 0; c < 500 && bus.FSMSTAT; c++) begin
            if (bus.RF_EN && !prev && np < 10) begin
                ph[np] = int'(bus.RF_PHASE);
                np++;
            end
            if (c == 6) chk("phase_hold_dacq", bus.RF_PHASE, 1);
            prev = bus.RF_EN;
            @(negedge clk);
        end
        chk("phase_pulses", np, 10);
        for (int i = 0; i < 10; i++) chk($sformatf("phase_%0d", i), ph[i], exp_ph[i]);
        chk("phase_scan_end", bus.SCAN_IDX, 5);

        // T1 inversion with table entry 0 = 2: T1P at phase 3, P90 at phase 2.
        bus.PHASE_TABLE = 8'hE6;
        set_cfg(mk(6, 10, 4, 4, 8, 32, 0, 0, 0, 0, 1, 0,0,0,0,0,0,0,0));
        kick();
        for (int c = 0; c < 40; c++) begin
            rfa[c] = bus.RF_EN;
            pha[c] = bus.RF_PHASE;
            dna_[c] = bus.DONE;
            @(negedge clk);
        end
        chk("t1_rf_c0", rfa[0], 1);
        chk("t1_ph_c0", pha[0], 3);
        chk("t1_rf_c5", rfa[5], 1);
        chk("t1_rf_c6", rfa[6], 0);
        chk("t1_ph_hold_c6", pha[6], 3);
        chk("t1_rf_c15", rfa[15], 0);
        chk("t1_rf_c16", rfa[16], 1);
        chk("t1_ph_c16", pha[16], 2);
        chk("t1_rf_c20", rfa[20], 0);
        chk("t1_done_c24", dna_[24], 0);
        chk("t1_done_c25", dna_[25], 1);
        bus.PHASE_TABLE = 8'hE4;

        // Abort during the second echo.
        set_cfg(vt[0]);
        kick();
        wait_dacq(1, "abort");
        bus.ABORT = 1'b1;
        @(negedge clk);
        bus.ABORT = 1'b0;
        chk("abort_fsmstat", bus.FSMSTAT, 0);
        chk("abort_gates", {bus.RF_EN, bus.EN_RX, bus.TX_SD, bus.ACQ_WND}, 0);
        chk("abort_echo_hold", bus.ECHO_IDX, 1);
        chk("abort_scan_hold", bus.SCAN_IDX, 0);
        dn = 0; busy = 0;
        for (int c = 0; c < 20; c++) begin
            dn += int'(bus.DONE);
            busy += int'(bus.FSMSTAT);
            @(negedge clk);
        end
        chk("abort_no_done", dn, 0);
        chk("abort_stays_idle", busy, 0);

        // Reset pulse mid-DACQ.
        kick();
        wait_dacq(0, "reset");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_fsmstat", {bus.FSMSTAT, bus.DONE}, 0);
        chk("midrst_gates", {bus.RF_EN, bus.EN_RX, bus.TX_SD, bus.ACQ_WND}, 0);
        chk("midrst_phase_idx", {bus.RF_PHASE, bus.ECHO_IDX, bus.SCAN_IDX}, 0);
        repeat (3) @(negedge clk);
        chk("midrst_stays_idle", bus.FSMSTAT, 0);

        // START held high: 5-cycle runs separated by one IDLE cycle.
        set_cfg(mk(0, 0, 2, 1, 8, 8, 0, 0, 0, 0, 1, 0,0,0,0,0,0,0,0));
        @(negedge clk);
        bus.START = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 40; c++) begin
            fs[c] = bus.FSMSTAT;
            dns[c] = bus.DONE;
            @(negedge clk);
        end
        bus.START = 1'b0;
        chk("b2b_busy_c0", fs[0], 1);
        chk("b2b_done_c4", dns[4], 1);
        chk("b2b_idle_c5", fs[5], 0);
        chk("b2b_busy_c6", fs[6], 1);
        chk("b2b_done_c10", dns[10], 1);
        chk("b2b_idle_c11", fs[11], 0);
        chk("b2b_busy_c12", fs[12], 1);
        wait_idle("b2b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
